axis_video_frame_tx: RTL and testbench

// - Transmit side of the AXI4-Stream video link feeding the gradient pipeline and the frame-capture bench.
// - On a start pulse, reads one frame (HEIGHT x WIDTH pixels) from a synchronous-read frame RAM in raster order.
// - Emits the frame as AXI4-Stream: tuser marks start of frame, tlast marks end of line; honours tready backpressure.
//

---
 rtl/axis_video_tx_pkg.sv | 25 ++
 rtl/axis_skid_buffer.sv | 44 ++++
 rtl/axis_video_frame_tx.sv | 154 +++++++++++++++
 tb/tb_axis_video_frame_tx.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_video_tx_pkg.sv
// Shared types for the AXI4-Stream video frame transmitter and its output buffer.
package axis_video_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_BLANK = 2'd2,
    ST_DRAIN = 2'd3
  } tx_state_e;

  typedef struct packed {
    logic tuser;
    logic tlast;
  } beat_side_t;

  localparam int SIDE_W = $bits(beat_side_t);

  function automatic beat_side_t make_side(input logic first, input logic last);
    beat_side_t s;
    s.tuser = first;
    s.tlast = last;
    return s;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry stream buffer; the writer must only push when it knows a slot will be free.
module axis_skid_buffer #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic [1:0]   level
);

  logic [W-1:0] slot [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         pop;

  assign m_valid = (level != 2'd0);
  assign pop     = m_valid & m_ready;
  // Head slot is not rewritten until popped, so data stays stable during a stall.
  assign m_data  = slot[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot[0] <= '0;
      slot[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      level   <= 2'd0;
    end else begin
      if (s_valid) begin
        slot[wr_ptr] <= s_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      level <= level + {1'b0, s_valid} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/axis_video_frame_tx.sv
// Reads one frame from a sync-read RAM in raster order and emits it as AXI4-Stream video.
//   state | meaning
//   IDLE  | waiting for i_start
//   READ  | issuing RAM reads while buffer space allows
//   BLANK | horizontal blanking between lines, no reads
//   DRAIN | all reads issued, waiting for the last beat to leave
module axis_video_frame_tx
  import axis_video_tx_pkg::*;
#(
  parameter int N       = 32,
  parameter int HEIGHT  = 355,
  parameter int WIDTH   = 355,
  parameter int ADDR_W  = 17,
  parameter int H_BLANK = 0
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_aresetn,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [N-1:0]      i_mem_rd_data,
  output logic [N-1:0]      o_video_tdata,
  output logic              o_video_tvalid,
  input  logic              i_video_tready,
  output logic              o_video_tlast,
  output logic              o_video_tuser
);

  localparam int PIX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int LINE_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int BLK_W  = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;
  localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'((H_BLANK > 0) ? H_BLANK - 1 : 0);

  tx_state_e         state;
  logic [PIX_W-1:0]  pix;
  logic [LINE_W-1:0] line;
  logic [BLK_W-1:0]  blank_cnt;
  logic [ADDR_W-1:0] addr;
  logic              in_flight;
  beat_side_t        side_q;
  beat_side_t        side_now;
  beat_side_t        head_side;

  logic [1:0]        level;
  logic              buf_valid;
  logic              pop;
  logic [2:0]        occ;
  logic              rd_en;
  logic              pix_last;
  logic              line_last;
  logic [N+1:0]      head_data;

  assign pix_last  = (pix == PIX_W'(WIDTH - 1));
  assign line_last = (line == LINE_W'(HEIGHT - 1));
  assign side_now  = make_side((pix == '0) && (line == '0), pix_last);

  // Occupancy counted after this cycle's handshake, so a beat leaving now frees
  // its slot for a read issued now; this keeps 1 beat/clock with a 2-entry buffer.
  assign pop   = buf_valid & i_video_tready;
  assign occ   = {1'b0, level} + {2'b0, in_flight} - {2'b0, pop};
  assign rd_en = (state == ST_READ) && (occ < 3'd2);

  assign o_mem_rd_en = rd_en;
  assign o_mem_addr  = addr;

  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      state        <= ST_IDLE;
      pix          <= '0;
      line         <= '0;
      blank_cnt    <= '0;
      addr         <= '0;
      in_flight    <= 1'b0;
      side_q       <= '0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      in_flight    <= rd_en;
      o_frame_done <= 1'b0;
      if (rd_en) begin
        side_q <= side_now;
      end
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state  <= ST_READ;
            o_busy <= 1'b1;
            pix    <= '0;
            line   <= '0;
            addr   <= '0;
          end
        end
        ST_READ: begin
          if (rd_en) begin
            addr <= addr + ADDR_W'(1);
            if (pix_last) begin
              pix <= '0;
              if (line_last) begin
                line  <= '0;
                state <= ST_DRAIN;
              end else begin
                line <= line + LINE_W'(1);
                if (H_BLANK > 0) begin
                  state     <= ST_BLANK;
                  blank_cnt <= BLK_LOAD;
                end
              end
            end else begin
              pix <= pix + PIX_W'(1);
            end
          end
        end
        ST_BLANK: begin
          if (blank_cnt == '0) begin
            state <= ST_READ;
          end else begin
            blank_cnt <= blank_cnt - BLK_W'(1);
          end
        end
        ST_DRAIN: begin
          // occ==0: nothing in flight and the last stored beat leaves this cycle.
          if (occ == 3'd0) begin
            state        <= ST_IDLE;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  axis_skid_buffer #(
    .W (N + SIDE_W)
  ) u_skid (
    .clk     (i_sys_clk),
    .rst_n   (i_sys_aresetn),
    .s_valid (in_flight),
    .s_data  ({side_q, i_mem_rd_data}),
    .m_valid (buf_valid),
    .m_ready (i_video_tready),
    .m_data  (head_data),
    .level   (level)
  );

  assign head_side      = beat_side_t'(head_data[N+1:N]);
  assign o_video_tdata  = head_data[N-1:0];
  assign o_video_tvalid = buf_valid;
  assign o_video_tlast  = buf_valid & head_side.tlast;
  assign o_video_tuser  = buf_valid & head_side.tuser;

endmodule

// File: tb/tb_axis_video_frame_tx.sv
// Directed bench for axis_video_frame_tx on a 4x3 frame with RAM data[a]=a.
module tb_axis_video_frame_tx;

  localparam int N  = 32;
  localparam int H  = 3;
  localparam int W  = 4;
  localparam int AW = 17;

  typedef struct {
    logic [AW-1:0] addr;
    logic [N-1:0]  tdata;
    logic          tuser;
    logic          tlast;
  } vec_t;

  vec_t tab [12];
  int   exp_gap [11];

  int total = 0;
  int bad   = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_start = 1'b0, a_ready = 1'b0;
  logic          a_busy, a_done, a_rd_en, a_tvalid, a_tlast, a_tuser;
  logic [AW-1:0] a_addr;
  logic [N-1:0]  a_rdata, a_tdata;

  logic          b_start = 1'b0, b_ready = 1'b0;
  logic          b_busy, b_done, b_rd_en, b_tvalid, b_tlast, b_tuser;
  logic [AW-1:0] b_addr;
  logic [N-1:0]  b_rdata, b_tdata;

  axis_video_frame_tx #(.N(N), .HEIGHT(H), .WIDTH(W), .ADDR_W(AW), .H_BLANK(0)) dut_a (
    .i_sys_clk(clk), .i_sys_aresetn(rst_n), .i_start(a_start), .o_busy(a_busy),
    .o_frame_done(a_done), .o_mem_rd_en(a_rd_en), .o_mem_addr(a_addr),
    .i_mem_rd_data(a_rdata), .o_video_tdata(a_tdata), .o_video_tvalid(a_tvalid),
    .i_video_tready(a_ready), .o_video_tlast(a_tlast), .o_video_tuser(a_tuser));

  axis_video_frame_tx #(.N(N), .HEIGHT(H), .WIDTH(W), .ADDR_W(AW), .H_BLANK(3)) dut_b (
    .i_sys_clk(clk), .i_sys_aresetn(rst_n), .i_start(b_start), .o_busy(b_busy),
    .o_frame_done(b_done), .o_mem_rd_en(b_rd_en), .o_mem_addr(b_addr),
    .i_mem_rd_data(b_rdata), .o_video_tdata(b_tdata), .o_video_tvalid(b_tvalid),
    .i_video_tready(b_ready), .o_video_tlast(b_tlast), .o_video_tuser(b_tuser));

  always_ff @(posedge clk) begin
    if (a_rd_en) a_rdata <= N'(a_addr);
    if (b_rd_en) b_rdata <= N'(b_addr);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N+1:0]  a_log [256];
  int            a_log_cyc [256];
  int            a_nb = 0, a_rd_cnt = 0, a_done_cnt = 0, a_done_cyc = 0;
  logic [N+1:0]  b_log [64];
  logic [AW-1:0] b_rd_addr [64];
  int            b_rd_cyc [64];
  int            b_nb = 0, b_nrd = 0;
  logic          prev_stall = 1'b0;
  logic [N+2:0]  prev_beat = '0;

  always @(negedge clk) begin
    if (rst_n && prev_stall)
      chk("stall_hold", 64'({a_tvalid, a_tuser, a_tlast, a_tdata}), 64'(prev_beat));
    prev_stall <= rst_n && a_tvalid && !a_ready;
    prev_beat  <= {1'b1, a_tuser, a_tlast, a_tdata};
    if (a_tvalid && a_ready && a_nb < 256) begin
      a_log[a_nb]     <= {a_tuser, a_tlast, a_tdata};
      a_log_cyc[a_nb] <= cyc;
      a_nb            <= a_nb + 1;
    end
    if (a_rd_en) a_rd_cnt <= a_rd_cnt + 1;
    if (a_done) begin
      a_done_cnt <= a_done_cnt + 1;
      a_done_cyc <= cyc;
    end
    if (b_rd_en && b_nrd < 64) begin
      b_rd_addr[b_nrd] <= b_addr;
      b_rd_cyc[b_nrd]  <= cyc;
      b_nrd            <= b_nrd + 1;
    end
    if (b_tvalid && b_ready && b_nb < 64) begin
      b_log[b_nb] <= {b_tuser, b_tlast, b_tdata};
      b_nb        <= b_nb + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
    #1;
  endtask

  function automatic logic rdy(input int mode, input int k);
    if (mode == 1) return 1'($urandom_range(0, 1));
    if (mode == 2) return (k >= 20);
    return 1'b1;
  endfunction

  task automatic check_frame(input string tag, input int base, input int which, input int nb);
    logic [N+1:0] act;
    chk({tag, "_count"}, 64'(nb - base), 64'd12);
    for (int i = 0; i < 12; i++) begin
      act = (which == 1) ? b_log[base + i] : a_log[base + i];
      chk($sformatf("%s_beat%0d", tag, i), 64'(act),
          64'({tab[i].tuser, tab[i].tlast, tab[i].tdata}));
    end
  endtask

  // mode 0: tready high, 1: random tready, 2: tready low 20 cycles, 3: i_start held high
  task automatic run_frame(input int mode);
    int  base_rd;
    bit  got;
    got     = 1'b0;
    base_rd = a_rd_cnt;
    step();
    a_start = 1'b1;
    a_ready = rdy(mode, 0);
    for (int k = 0; k < 300; k++) begin
      if (k > 0) begin
        step();
        a_start = (mode == 3);
        a_ready = rdy(mode, k);
      end
      samp();
      if (mode == 0 && k == 0) chk("idle_busy", 64'(a_busy), 64'd0);
      if (mode == 0 && k == 1)
        chk("lat_first_read", 64'({a_busy, a_rd_en, a_addr}), 64'({1'b1, 1'b1, 17'd0}));
      if (mode == 0 && k == 2) chk("lat_no_valid", 64'(a_tvalid), 64'd0);
      if (mode == 0 && k == 3)
        chk("lat_first_valid", 64'({a_tvalid, a_tuser, a_tdata}), 64'({1'b1, 1'b1, 32'd0}));
      if (mode == 2 && k == 19) begin
        chk("stall_reads", 64'(a_rd_cnt - base_rd), 64'd2);
        chk("stall_valid", 64'({a_tvalid, a_tdata}), 64'({1'b1, 32'd0}));
      end
      if (a_done) begin
        got = 1'b1;
        break;
      end
    end
    chk("frame_done_seen", 64'(got), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int  base, base_done, base_rd;
    bit  got;

    tab[0]  = '{0,  0,  1'b1, 1'b0};
    tab[1]  = '{1,  1,  1'b0, 1'b0};
    tab[2]  = '{2,  2,  1'b0, 1'b0};
    tab[3]  = '{3,  3,  1'b0, 1'b1};
    tab[4]  = '{4,  4,  1'b0, 1'b0};
    tab[5]  = '{5,  5,  1'b0, 1'b0};
    tab[6]  = '{6,  6,  1'b0, 1'b0};
    tab[7]  = '{7,  7,  1'b0, 1'b1};
    tab[8]  = '{8,  8,  1'b0, 1'b0};
    tab[9]  = '{9,  9,  1'b0, 1'b0};
    tab[10] = '{10, 10, 1'b0, 1'b0};
    tab[11] = '{11, 11, 1'b0, 1'b1};
    exp_gap = '{1, 1, 1, 4, 1, 1, 1, 4, 1, 1, 1};

    // reset state
    repeat (3) samp();
    chk("rst_ctrl", 64'({a_busy, a_done, a_rd_en, a_tvalid, a_tlast, a_tuser}), 64'd0);
    chk("rst_addr", 64'(a_addr), 64'd0);
    chk("rst_tdata", 64'(a_tdata), 64'd0);
    step();
    rst_n = 1'b1;
    repeat (2) step();

    // full-rate frame
    base = a_nb;
    base_done = a_done_cnt;
    run_frame(0);
    check_frame("fullrate", base, 0, a_nb);
    chk("fullrate_consecutive", 64'(a_log_cyc[base + 11] - a_log_cyc[base]), 64'd11);
    chk("done_after_last", 64'(a_done_cyc), 64'(a_log_cyc[base + 11] + 1));
    step();
    samp();
    chk("done_one_pulse", 64'({a_done, a_busy}), 64'd0);
    chk("done_count", 64'(a_done_cnt - base_done), 64'd1);

    // random backpressure
    repeat (2) step();
    base = a_nb;
    run_frame(1);
    check_frame("random", base, 0, a_nb);

    // held-off start of frame
    repeat (2) step();
    base = a_nb;
    run_frame(2);
    check_frame("stall20", base, 0, a_nb);

    // horizontal blanking instance
    step();
    a_ready = 1'b1;
    base    = b_nb;
    base_rd = b_nrd;
    b_ready = 1'b1;
    b_start = 1'b1;
    got     = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
      b_start = 1'b0;
      samp();
      if (b_done) begin
        got = 1'b1;
        break;
      end
    end
    chk("blank_done_seen", 64'(got), 64'd1);
    chk("blank_reads", 64'(b_nrd - base_rd), 64'd12);
    for (int i = 0; i < 12; i++)
      chk($sformatf("blank_addr%0d", i), 64'(b_rd_addr[base_rd + i]), 64'(tab[i].addr));
    for (int i = 0; i < 11; i++)
      chk($sformatf("blank_gap%0d", i),
          64'(b_rd_cyc[base_rd + i + 1] - b_rd_cyc[base_rd + i]), 64'(exp_gap[i]));
    check_frame("blank", base, 1, b_nb);

    // start held high: ignored while busy, accepted on the done cycle
    repeat (2) step();
    base = a_nb;
    run_frame(3);
    check_frame("heldstart1", base, 0, a_nb);
    step();
    a_start = 1'b0;
    samp();
    chk("b2b_restart", 64'({a_busy, a_rd_en, a_addr}), 64'({1'b1, 1'b1, 17'd0}));
    base = a_nb;
    got  = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
      samp();
      if (a_done) begin
        got = 1'b1;
        break;
      end
    end
    chk("b2b_done_seen", 64'(got), 64'd1);
    check_frame("heldstart2", base, 0, a_nb);

    // async reset mid-frame, after beat 5
    repeat (2) step();
    base    = a_nb;
    a_start = 1'b1;
    got     = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      a_start = 1'b0;
      samp();
      if (a_nb - base >= 6) begin
        got = 1'b1;
        break;
      end
    end
    chk("mid_beats_seen", 64'(got), 64'd1);
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", 64'({a_busy, a_done, a_rd_en, a_tvalid, a_tlast, a_tuser}), 64'd0);
    chk("midrst_data", 64'({a_addr, a_tdata}), 64'd0);
    chk("midrst_beats", 64'(a_nb - base), 64'd6);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    base = a_nb;
    run_frame(0);
    check_frame("replay", base, 0, a_nb);

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
